memc_collect: RTL
=================

// Module: memc_collect
// PURPOSE
//  Output-side counterpart of the A/B skew loaders: drains the systolic array's C results.
//  Lane x of Cin arrives x en-cycles after lane 0; the block de-skews all lanes back into
//  whole rows, stores DIM rows in a row buffer, then serves them by row index to the host.
//  Sits between the systolic array result lanes and the MMIO read path.
// PARAMETERS
//  BITS_C  16  signed width of one C element
//  DIM     8   array dimension: lanes per row and rows per matrix
// PORTS
//  clk     in   1                clock; all state on posedge
//  rst_n   in   1                asynchronous active-low reset
//  start   in   1                pulse: clear state and begin a new capture
//  en      in   1                advance enable; de-skew pipe and capture move only when en=1
//  Cin_vld in   1                lane-0-aligned valid for the current Cin row
//  Cin     in   BITS_C x DIM     skewed signed result lanes, lane x delayed x en-cycles
//  rd_en   in   1                read request for row Crow
//  Crow    in   $clog2(DIM)      row index to read
//  Cout    out  BITS_C x DIM     registered read data
//  Cout_vld out 1                Cout valid, one cycle after accepted rd_en
//  busy    out  1                capture in progress
//  done    out  1                DIM rows captured; buffer readable
//  err     out  1                sticky: valid row arrived while DONE
// BEHAVIOUR
//  Reset: state=IDLE, wr_row=0, vld pipe=0, Cout=0, Cout_vld=0, busy=0, done=0, err=0.
//   Row-buffer contents undefined after reset.
//  De-skew: lane x passes a DIM-1-x stage en-gated delay; lane DIM-1 is combinational bypass.
//   Cin_vld passes a DIM-1 stage en-gated shift register -> aligned_vld.
//   Delays hold when en=0.
//  FSM (IDLE, CAPTURE, DONE):
//   IDLE:    start -> CAPTURE.
//   CAPTURE: en & aligned_vld -> write de-skewed row at wr_row, wr_row++;
//            write of row DIM-1 -> DONE.
//   DONE:    en & aligned_vld -> no write, err<=1. start -> CAPTURE.
//  start: top priority in any state. Same cycle: wr_row<=0, vld pipe<=0, done<=0, err<=0,
//   state<=CAPTURE. Data delay stages are not cleared. Start mid-capture discards partial rows.
//  busy = (state==CAPTURE); done = (state==DONE); both are registered state decodes.
//  Latency: lane-0 element sampled at en-cycle t, with its row complete at lane DIM-1
//   at t+DIM-1. Row is written on the edge ending en-cycle t+DIM-1; readable next cycle.
//  Read: rd_en accepted only when done=1.
//   Accepted: Cout <= buf[Crow], Cout_vld <= 1 next cycle.
//   Otherwise: Cout_vld <= 0 and Cout holds.
//   rd_en is independent of en; back-to-back reads allowed, one row per cycle.
//  rd_en with start in the same cycle: the read is rejected.
//  Crow >= DIM when DIM is not a power of 2: Cout <= 0, Cout_vld <= 1.
//  No arithmetic on data: values stored bit-exact, signed.
// STRUCTURE
//  Shared package memc_pkg: typedef enum logic[1:0] {IDLE, CAPTURE, DONE} memc_state_t.
//  Delay lines: reuse existing en-gated `fifo` (DEPTH, BITS), one per lane x<DIM-1,
//   DEPTH=DIM-1-x, in a generate loop.
//  Valid pipe, FSM, row buffer and read port are inline in this module.
// TESTING (DIM=4, BITS_C=16)
//  Reset, then rd_en=1 Crow=0 -> Cout_vld=0, Cout=0, done=0, busy=0.
//  start; stream rows r=0..3, lane x value = 16*r+x, skewed per lane, en=1 continuous
//   -> done after 4+3 en-cycles; reads Crow=0..3 return {16r+3..16r}, Cout_vld the next cycle.
//  Same stream with en toggling 1,0 -> identical buffer contents; done delayed by the en=0 cycles.
//  Negative values (-1, -32768) on all lanes -> read back bit-exact.
//  start reissued after 2 rows written -> wr_row=0; new 4-row stream fully overwrites;
//   done only after 4 new rows.
//  Extra aligned row after DONE -> err=1, buffer unchanged; next start clears err.
//  Async: rst_n low mid-CAPTURE, released between clock edges -> all outputs 0 immediately;
//   state IDLE.

Source files
------------

// File: rtl/memc_pkg.sv
// Shared definitions for the C-result collector: FSM state encoding and
// a helper that gives the de-skew delay depth of each result lane.
package memc_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CAPTURE = 2'd1,
      DONE    = 2'd2
   } memc_state_t;

   // Lane x arrives x en-cycles late, so it needs dim-1-x stages to realign.
   function automatic int lane_depth(input int dim, input int lane);
      return dim - 1 - lane;
   endfunction

endpackage

// File: rtl/fifo.sv
// En-gated fixed-depth delay line. Data advances one stage per cycle with
// en=1 and holds otherwise; dout is the value that entered DEPTH en-cycles ago.
module fifo #(
   parameter int DEPTH = 1,
   parameter int BITS  = 16
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            en,
   input  logic [BITS-1:0] din,
   output logic [BITS-1:0] dout
);

   logic [BITS-1:0] stage_r [DEPTH];

   // Shift the delay chain on every enabled cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            stage_r[i] <= '0;
         end
      end else if (en) begin
         stage_r[0] <= din;
         for (int i = 1; i < DEPTH; i++) begin
            stage_r[i] <= stage_r[i-1];
         end
      end
   end

   assign dout = stage_r[DEPTH-1];

endmodule

// File: rtl/memc_collect.sv
// Result collector for the systolic array: realigns the skewed C lanes into
// whole rows, captures DIM rows into a row buffer and serves them by index.
module memc_collect
   import memc_pkg::*;
#(
   parameter int BITS_C = 16,
   parameter int DIM    = 8
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic                              start,
   input  logic                              en,
   input  logic                              Cin_vld,
   input  logic [DIM-1:0][BITS_C-1:0]        Cin,
   input  logic                              rd_en,
   input  logic [$clog2(DIM)-1:0]            Crow,
   output logic [DIM-1:0][BITS_C-1:0]        Cout,
   output logic                              Cout_vld,
   output logic                              busy,
   output logic                              done,
   output logic                              err
);

   localparam int RW = $clog2(DIM);

   // ------------------------------------------------------------------
   // De-skew: every lane but the last passes through its own delay line
   // ------------------------------------------------------------------
   logic [DIM-1:0][BITS_C-1:0] row_s;

   for (genvar x = 0; x < DIM - 1; x++) begin : g_lane
      fifo #(
         .DEPTH (lane_depth(DIM, x)),
         .BITS  (BITS_C)
      ) u_dly (
         .clk   (clk),
         .rst_n (rst_n),
         .en    (en),
         .din   (Cin[x]),
         .dout  (row_s[x])
      );
   end

   // The most-delayed lane is already aligned with the others.
   assign row_s[DIM-1] = Cin[DIM-1];

   // Valid follows lane 0 through the same DIM-1 en-gated stages.
   logic [DIM-2:0] vld_r;
   logic           aligned_vld_s;

   // Valid shift register; start flushes any rows still in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_r <= '0;
      end else if (start) begin
         vld_r <= '0;
      end else if (en) begin
         vld_r[0] <= Cin_vld;
         for (int i = 1; i < DIM - 1; i++) begin
            vld_r[i] <= vld_r[i-1];
         end
      end
   end

   assign aligned_vld_s = vld_r[DIM-2];

   // ------------------------------------------------------------------
   // Capture FSM
   // ------------------------------------------------------------------
   memc_state_t    state_r;
   memc_state_t    next_state_s;
   logic [RW-1:0]  wr_row_r;
   logic           row_event_s;
   logic           wr_fire_s;
   logic           err_fire_s;
   logic           last_row_s;
   logic           busy_r;
   logic           done_r;
   logic           err_r;

   assign row_event_s = en & aligned_vld_s & ~start;
   assign last_row_s  = (wr_row_r == RW'(DIM - 1));

   // Next-state selection; start wins over every other transition.
   always_comb begin
      next_state_s = state_r;
      if (start) begin
         next_state_s = CAPTURE;
      end else begin
         case (state_r)
            IDLE: begin
               next_state_s = IDLE;
            end
            CAPTURE: begin
               if (row_event_s && last_row_s) begin
                  next_state_s = DONE;
               end else begin
                  next_state_s = CAPTURE;
               end
            end
            DONE: begin
               next_state_s = DONE;
            end
            default: begin
               next_state_s = IDLE;
            end
         endcase
      end
   end

   // Per-state actions: row writes while capturing, overrun flag once done.
   always_comb begin
      wr_fire_s  = 1'b0;
      err_fire_s = 1'b0;
      case (state_r)
         CAPTURE: begin
            wr_fire_s = row_event_s;
         end
         DONE: begin
            err_fire_s = row_event_s;
         end
         default: begin
            wr_fire_s  = 1'b0;
            err_fire_s = 1'b0;
         end
      endcase
   end

   // State, write pointer and registered status flags.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r  <= IDLE;
         wr_row_r <= '0;
         busy_r   <= 1'b0;
         done_r   <= 1'b0;
         err_r    <= 1'b0;
      end else begin
         state_r <= next_state_s;
         busy_r  <= (next_state_s == CAPTURE);
         done_r  <= (next_state_s == DONE);
         if (start) begin
            wr_row_r <= '0;
            err_r    <= 1'b0;
         end else begin
            if (wr_fire_s) begin
               wr_row_r <= wr_row_r + RW'(1);
            end
            if (err_fire_s) begin
               err_r <= 1'b1;
            end
         end
      end
   end

   // ------------------------------------------------------------------
   // Row buffer and read port
   // ------------------------------------------------------------------
   logic [DIM-1:0][BITS_C-1:0] rowbuf_r [DIM];
   logic                       rd_acc_s;
   logic                       rd_in_range_s;

   // Row storage; contents are only meaningful once the capture completes.
   always_ff @(posedge clk) begin
      if (wr_fire_s) begin
         rowbuf_r[wr_row_r] <= row_s;
      end
   end

   assign rd_acc_s      = rd_en & done_r & ~start;
   assign rd_in_range_s = (int'(Crow) < DIM);

   // Registered read data; rejected requests drop valid and keep old data.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         Cout     <= '0;
         Cout_vld <= 1'b0;
      end else if (rd_acc_s) begin
         Cout_vld <= 1'b1;
         if (rd_in_range_s) begin
            Cout <= rowbuf_r[Crow];
         end else begin
            Cout <= '0;
         end
      end else begin
         Cout_vld <= 1'b0;
      end
   end

   assign busy = busy_r;
   assign done = done_r;
   assign err  = err_r;

endmodule
